// File: rtl/deconv_frame_sequencer.sv
// Frame-level sequencer for one deconvolution layer: reads one frame from a
// synchronous-read frame buffer, tags each pixel with line/frame framing, and
// holds off completion until the layer reports its own end of frame.
module deconv_frame_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int STRING_LEN  = 224,
  parameter int STRING_NUM  = 224,
  parameter int HOLD_DATA   = 16,
  parameter int MEM_LATENCY = 2,
  localparam int ADDR_WIDTH = $clog2(STRING_LEN*STRING_NUM)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  layer_eof_i,
  output logic                  mem_rd_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_valid_o,
  output logic                  sop_o,
  output logic                  eop_o,
  output logic                  sof_o,
  output logic                  eof_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [15:0]           frame_cnt_o
);

  localparam int CW = (STRING_LEN > 1) ? $clog2(STRING_LEN) : 1;
  localparam int RW = (STRING_NUM > 1) ? $clog2(STRING_NUM) : 1;
  localparam int HW = (HOLD_DATA  > 1) ? $clog2(HOLD_DATA)  : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                r_state;
  logic [HW-1:0]         r_hold;
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_rd;
  logic                  r_busy;
  logic                  r_done;
  logic [15:0]           r_frame_cnt;

  // Tag bits: {strobe, sop, eop, sof, eof}
  logic [4:0]            r_tag_p0 [MEM_LATENCY];

  logic [DATA_WIDTH-1:0] r_data_p1;
  logic                  r_vld_p1;
  logic                  r_sop_p1;
  logic                  r_eop_p1;
  logic                  r_sof_p1;
  logic                  r_eof_p1;

  logic                  w_col_last;
  logic                  w_last;
  logic [HW-1:0]         w_hold_nxt;
  logic [4:0]            w_tag;

  // col/row/addr always describe the read being issued while r_rd is high
  assign w_col_last = (r_col == CW'(STRING_LEN-1));
  assign w_last     = w_col_last && (r_row == RW'(STRING_NUM-1));
  assign w_hold_nxt = (r_hold == HW'(HOLD_DATA-1)) ? '0 : r_hold + 1'b1;
  assign w_tag      = {r_rd, (r_col == '0), w_col_last,
                       (r_col == '0) && (r_row == '0), w_last};

  // Frame FSM: read issue timing, address walk, handshake and frame count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_addr      <= '0;
      r_rd        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state <= S_STREAM;
            r_busy  <= 1'b1;
            r_hold  <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_addr  <= '0;
            r_rd    <= 1'b1;
          end
        end
        S_STREAM: begin
          r_hold <= w_hold_nxt;
          if (r_rd && w_last) begin
            r_state <= S_DRAIN;
            r_rd    <= 1'b0;
          end else begin
            r_rd <= (w_hold_nxt == '0);
            if (r_rd) begin
              r_addr <= r_addr + 1'b1;
              if (w_col_last) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
              end else begin
                r_col <= r_col + 1'b1;
              end
            end
          end
        end
        S_DRAIN: begin
          if (layer_eof_i) begin
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_frame_cnt <= r_frame_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_rd    <= 1'b0;
        end
      endcase
    end
  end

  // Read-latency shift line: framing tags travel with the read strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_LATENCY; i++) r_tag_p0[i] <= '0;
    end else begin
      r_tag_p0[0] <= w_tag;
      for (int i = 1; i < MEM_LATENCY; i++) r_tag_p0[i] <= r_tag_p0[i-1];
    end
  end

  // Output stage: capture memory data when the delayed strobe arrives
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_p1 <= '0;
      r_vld_p1  <= 1'b0;
      r_sop_p1  <= 1'b0;
      r_eop_p1  <= 1'b0;
      r_sof_p1  <= 1'b0;
      r_eof_p1  <= 1'b0;
    end else if (r_tag_p0[MEM_LATENCY-1][4]) begin
      r_data_p1 <= mem_data_i;
      r_vld_p1  <= 1'b1;
      r_sop_p1  <= r_tag_p0[MEM_LATENCY-1][3];
      r_eop_p1  <= r_tag_p0[MEM_LATENCY-1][2];
      r_sof_p1  <= r_tag_p0[MEM_LATENCY-1][1];
      r_eof_p1  <= r_tag_p0[MEM_LATENCY-1][0];
    end else begin
      r_vld_p1  <= 1'b0;
      r_sop_p1  <= 1'b0;
      r_eop_p1  <= 1'b0;
      r_sof_p1  <= 1'b0;
      r_eof_p1  <= 1'b0;
    end
  end

  assign mem_rd_o     = r_rd;
  assign mem_addr_o   = r_addr;
  assign data_o       = r_data_p1;
  assign data_valid_o = r_vld_p1;
  assign sop_o        = r_sop_p1;
  assign eop_o        = r_eop_p1;
  assign sof_o        = r_sof_p1;
  assign eof_o        = r_eof_p1;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign frame_cnt_o  = r_frame_cnt;

endmodule
